load_hazard_stall_unit: RTL and testbench

Central stall/freeze controller for the 5-stage pipeline; it is the issuing end of the hazard path that MEM-stage store-data forwarding resolves.
- Detects load-use hazards in ID against a load in EX and inserts exactly one bubble.
- Store-data (rs2) dependencies are exempt from the bubble, because WB->MEM forwarding covers them.
- Freezes the whole pipeline while the data memory is not ready, with a timeout that raises a sticky fault.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/load_hazard_stall_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_hazard_stall_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_stall_unit.sv
// Central stall/freeze controller for the 5-stage pipeline: one-cycle load-use
// bubble, data-memory wait freeze with timeout fault, saturating stall counter.
module load_hazard_stall_unit #(
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic             ID_MemWrite,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_rd,
    input  logic             Branch_Taken,
    input  logic             MEM_Req,
    input  logic             Dmem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             Mem_Fault,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_BUBBLE = 2'd1;
    localparam logic [1:0] MODE_FREEZE = 2'd2;
    localparam logic [1:0] MODE_RESET  = 2'd3;

    logic              rs1_hit_s;
    logic              rs2_hit_s;
    logic              lu_s;
    logic              mw_s;
    logic              bubble_req_s;
    logic              wait_last_s;
    logic              stall_cycle_s;
    logic              count_full_s;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [1:0]        mode_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [CNT_W-1:0]  stall_count_r;

    // Store-data (rs2 of a store) is forwarded WB->MEM, so it never needs a bubble.
    assign rs1_hit_s    = ID_UsesRs1 & (ID_rs1 == EX_rd);
    assign rs2_hit_s    = ID_UsesRs2 & (ID_rs2 == EX_rd) & ~ID_MemWrite;
    assign lu_s         = EX_MemRead & EX_RegWrite & (EX_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
    assign mw_s         = MEM_Req & ~Dmem_Ready;
    assign bubble_req_s = lu_s & ~Branch_Taken;
    assign wait_last_s  = (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

    // Next-state, wait counter and output mode selection.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        mode_s         = MODE_FREEZE;
        case (state_r)
            ST_RUN: begin
                if (mw_s) begin
                    mode_s         = MODE_FREEZE;
                    wait_cnt_nxt_s = WAIT_W'(1);
                    if (TIMEOUT == 1) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        state_nxt_s = ST_MEM_WAIT;
                    end
                end else if (bubble_req_s) begin
                    mode_s = MODE_BUBBLE;
                end else begin
                    mode_s = MODE_NORMAL;
                end
            end
            ST_MEM_WAIT: begin
                if (mw_s) begin
                    mode_s = MODE_FREEZE;
                    if (wait_last_s) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end else begin
                    // Held ID/EX contents are re-evaluated on the release cycle.
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = '0;
                    if (bubble_req_s) begin
                        mode_s = MODE_BUBBLE;
                    end else begin
                        mode_s = MODE_NORMAL;
                    end
                end
            end
            ST_FAULT: begin
                mode_s      = MODE_FREEZE;
                state_nxt_s = ST_FAULT;
            end
            default: begin
                mode_s         = MODE_FREEZE;
                state_nxt_s    = ST_FAULT;
                wait_cnt_nxt_s = '0;
            end
        endcase
        if (rst) begin
            mode_s = MODE_RESET;
        end else begin
            mode_s = mode_s;
        end
    end

    // Decode the output mode into pipeline register controls.
    always_comb begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        IDEX_Bubble  = 1'b1;
        EXMEM_Write  = 1'b0;
        MEMWB_Bubble = 1'b1;
        case (mode_s)
            MODE_NORMAL: begin
                PC_Write     = 1'b1;
                IFID_Write   = 1'b1;
                IDEX_Write   = 1'b1;
                IDEX_Bubble  = 1'b0;
                EXMEM_Write  = 1'b1;
                MEMWB_Bubble = 1'b0;
            end
            MODE_BUBBLE: begin
                PC_Write     = 1'b0;
                IFID_Write   = 1'b0;
                IDEX_Write   = 1'b1;
                IDEX_Bubble  = 1'b1;
                EXMEM_Write  = 1'b1;
                MEMWB_Bubble = 1'b0;
            end
            MODE_FREEZE: begin
                PC_Write     = 1'b0;
                IFID_Write   = 1'b0;
                IDEX_Write   = 1'b0;
                IDEX_Bubble  = 1'b0;
                EXMEM_Write  = 1'b0;
                MEMWB_Bubble = 1'b1;
            end
            default: begin
                PC_Write     = 1'b0;
                IFID_Write   = 1'b0;
                IDEX_Write   = 1'b0;
                IDEX_Bubble  = 1'b1;
                EXMEM_Write  = 1'b0;
                MEMWB_Bubble = 1'b1;
            end
        endcase
    end

    // Controller state and memory-wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign stall_cycle_s = (mode_s == MODE_FREEZE) | (mode_s == MODE_BUBBLE);
    assign count_full_s  = (stall_count_r == {CNT_W{1'b1}});

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= '0;
        end else if (stall_cycle_s && !count_full_s) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign Mem_Fault   = (state_r == ST_FAULT);
    assign Stall_Count = stall_count_r;

endmodule

// File: tb/tb_load_hazard_stall_unit.sv
// Self-checking bench for load_hazard_stall_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_load_hazard_stall_unit;

    localparam int TIMEOUT = 4;
    localparam int WAIT_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = 15;

    logic             clk;
    logic             rst;
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_UsesRs1;
    logic             ID_UsesRs2;
    logic             ID_MemWrite;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_rd;
    logic             Branch_Taken;
    logic             MEM_Req;
    logic             Dmem_Ready;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             IDEX_Bubble;
    logic             EXMEM_Write;
    logic             MEMWB_Bubble;
    logic             Mem_Fault;
    logic [CNT_W-1:0] Stall_Count;

    int n_checks = 0;
    int n_fail   = 0;

    load_hazard_stall_unit #(.TIMEOUT(TIMEOUT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .ID_MemWrite(ID_MemWrite), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_rd(EX_rd), .Branch_Taken(Branch_Taken), .MEM_Req(MEM_Req), .Dmem_Ready(Dmem_Ready),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble),
        .Mem_Fault(Mem_Fault), .Stall_Count(Stall_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: freeze whenever memory is waiting or faulted; fault after
    // TIMEOUT consecutive waiting cycles; bubble on an unflushed load-use otherwise.
    int m_streak;
    bit m_fault;
    int m_cnt;

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = ID_UsesRs1 && (ID_rs1 == EX_rd);
        hit2 = ID_UsesRs2 && (ID_rs2 == EX_rd) && !ID_MemWrite;
        return EX_MemRead && EX_RegWrite && (EX_rd != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic bit m_mw();
        return MEM_Req && !Dmem_Ready;
    endfunction

    function automatic bit m_freeze();
        return m_fault || m_mw();
    endfunction

    function automatic bit m_bubble();
        return !m_freeze() && m_lu() && !Branch_Taken;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_streak <= 0;
            m_fault  <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if ((m_freeze() || m_bubble()) && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            if (!m_fault) begin
                if (m_mw()) begin
                    m_streak <= m_streak + 1;
                    if (m_streak + 1 >= TIMEOUT) m_fault <= 1'b1;
                end else begin
                    m_streak <= 0;
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        logic [5:0] exp_ctl;
        logic [5:0] act_ctl;
        act_ctl = {PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble};
        if (rst)             exp_ctl = 6'b000101;
        else if (m_freeze()) exp_ctl = 6'b000001;
        else if (m_bubble()) exp_ctl = 6'b001110;
        else                 exp_ctl = 6'b111010;
        check("model_ctl", 32'(act_ctl), 32'(exp_ctl));
        check("model_fault", 32'(Mem_Fault), rst ? 32'd0 : 32'(m_fault));
        check("model_count", 32'(Stall_Count), rst ? 32'd0 : 32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
        ID_MemWrite = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_rd = 5'd0;
        Branch_Taken = 1'b0; MEM_Req = 1'b0; Dmem_Ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_rd = rd;
        ID_rs1 = rd; ID_UsesRs1 = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst_pc_write", 32'(PC_Write), 32'd0);
        check("rst_idex_bubble", 32'(IDEX_Bubble), 32'd1);
        check("rst_fault", 32'(Mem_Fault), 32'd0);
        check("rst_count", 32'(Stall_Count), 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        do_reset();

        // Load-use bubble, then normal flow
        set_lu(5'd5);
        @(negedge clk);
        check("lu_pc_write", 32'(PC_Write), 32'd0);
        check("lu_ifid_write", 32'(IFID_Write), 32'd0);
        check("lu_idex_bubble", 32'(IDEX_Bubble), 32'd1);
        check("lu_exmem_write", 32'(EXMEM_Write), 32'd1);
        step();
        EX_MemRead = 1'b0;
        @(negedge clk);
        check("lu_after_pc_write", 32'(PC_Write), 32'd1);
        check("lu_after_count", 32'(Stall_Count), 32'd1);
        step();

        // Store-data exemption, and the same pattern without the store
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_rd = 5'd7;
        ID_rs2 = 5'd7; ID_UsesRs2 = 1'b1; ID_MemWrite = 1'b1; ID_rs1 = 5'd3; ID_UsesRs1 = 1'b1;
        @(negedge clk);
        check("store_pc_write", 32'(PC_Write), 32'd1);
        check("store_idex_bubble", 32'(IDEX_Bubble), 32'd0);
        step();
        ID_MemWrite = 1'b0;
        @(negedge clk);
        check("rs2_use_bubble", 32'(IDEX_Bubble), 32'd1);
        step();

        // x0 destination never hazards
        clear_inputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_UsesRs1 = 1'b1;
        @(negedge clk);
        check("x0_pc_write", 32'(PC_Write), 32'd1);
        step();

        // Flush beats load-use
        set_lu(5'd5);
        Branch_Taken = 1'b1;
        @(negedge clk);
        check("flush_pc_write", 32'(PC_Write), 32'd1);
        check("flush_idex_bubble", 32'(IDEX_Bubble), 32'd0);
        step();
        clear_inputs();
        @(negedge clk);
        check("count_after_exempt", 32'(Stall_Count), 32'd2);
        step();

        // Memory wait: 3 freeze cycles then release
        do_reset();
        MEM_Req = 1'b1; Dmem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_pc_write", 32'(PC_Write), 32'd0);
            check("wait_memwb_bubble", 32'(MEMWB_Bubble), 32'd1);
            check("wait_exmem_write", 32'(EXMEM_Write), 32'd0);
            step();
        end
        Dmem_Ready = 1'b1;
        @(negedge clk);
        check("release_pc_write", 32'(PC_Write), 32'd1);
        check("release_memwb_bubble", 32'(MEMWB_Bubble), 32'd0);
        step();
        clear_inputs();
        @(negedge clk);
        check("wait_count", 32'(Stall_Count), 32'd3);
        check("wait_no_fault", 32'(Mem_Fault), 32'd0);
        step();

        // Timeout into sticky fault
        do_reset();
        MEM_Req = 1'b1; Dmem_Ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_freeze_pc", 32'(PC_Write), 32'd0);
            check("to_no_fault_yet", 32'(Mem_Fault), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_fault_set", 32'(Mem_Fault), 32'd1);
        step();
        Dmem_Ready = 1'b1;
        @(negedge clk);
        check("to_fault_sticky", 32'(Mem_Fault), 32'd1);
        check("to_fault_frozen", 32'(PC_Write), 32'd0);
        step();
        do_reset();
        @(negedge clk);
        check("to_cleared_fault", 32'(Mem_Fault), 32'd0);
        check("to_cleared_run", 32'(PC_Write), 32'd1);
        step();

        // Load-use pending across a freeze
        do_reset();
        set_lu(5'd9);
        MEM_Req = 1'b1; Dmem_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("pend_freeze_pc", 32'(PC_Write), 32'd0);
            check("pend_freeze_bubble", 32'(IDEX_Bubble), 32'd0);
            step();
        end
        Dmem_Ready = 1'b1;
        @(negedge clk);
        check("pend_bubble", 32'(IDEX_Bubble), 32'd1);
        check("pend_bubble_pc", 32'(PC_Write), 32'd0);
        check("pend_bubble_exmem", 32'(EXMEM_Write), 32'd1);
        check("pend_bubble_memwb", 32'(MEMWB_Bubble), 32'd0);
        step();
        clear_inputs();
        @(negedge clk);
        check("pend_normal_pc", 32'(PC_Write), 32'd1);
        check("pend_count", 32'(Stall_Count), 32'd3);
        step();

        // Saturation
        do_reset();
        set_lu(5'd12);
        repeat (20) step();
        clear_inputs();
        @(negedge clk);
        check("sat_count", 32'(Stall_Count), 32'd15);
        step();

        // Random traffic checked by the model, with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            EX_rd        = 5'($urandom_range(0, 3));
            ID_rs1       = 5'($urandom_range(0, 3));
            ID_rs2       = 5'($urandom_range(0, 3));
            ID_UsesRs1   = 1'($urandom_range(0, 1));
            ID_UsesRs2   = 1'($urandom_range(0, 1));
            ID_MemWrite  = 1'($urandom_range(0, 1));
            EX_MemRead   = 1'($urandom_range(0, 1));
            EX_RegWrite  = 1'($urandom_range(0, 1));
            Branch_Taken = ($urandom_range(0, 3) == 0);
            MEM_Req      = 1'($urandom_range(0, 1));
            Dmem_Ready   = ($urandom_range(0, 4) != 0);
            rst          = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
